// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings and the sequencer state type.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; on a tie the requester that did not win last time is chosen.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    grant_idx    = grant[1];
    last_grant_d = take ? grant[1] : last_grant_q;
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; one operation in flight at a time.
//   state | meaning
//   IDLE  | waiting for a request, grant evaluated
//   EXEC  | registered operands on the ALU, result captured at end of cycle
//   RESP  | response held for the owner until rsp_ready of the owner
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid0,
  input  logic               req_valid1,
  output logic               req_ready0,
  output logic               req_ready1,
  input  logic [DATA_W-1:0]  req_in1_0,
  input  logic [DATA_W-1:0]  req_in2_0,
  input  logic [OP_W-1:0]    req_opCode_0,
  input  logic [SHAMT_W-1:0] req_shiftAmt_0,
  input  logic [DATA_W-1:0]  req_in1_1,
  input  logic [DATA_W-1:0]  req_in2_1,
  input  logic [OP_W-1:0]    req_opCode_1,
  input  logic [SHAMT_W-1:0] req_shiftAmt_1,
  output logic               rsp_valid0,
  output logic               rsp_valid1,
  input  logic               rsp_ready0,
  input  logic               rsp_ready1,
  output logic [DATA_W-1:0]  rsp_result,
  output logic               rsp_overflow,
  output logic               rsp_zero,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output logic [OP_W-1:0]    alu_opCode,
  output logic [SHAMT_W-1:0] alu_shiftAmt,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               busy
);

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic [DATA_W-1:0]    alu_in1_q, alu_in1_d;
  logic [DATA_W-1:0]    alu_in2_q, alu_in2_d;
  logic [OP_W-1:0]      alu_op_q, alu_op_d;
  logic [SHAMT_W-1:0]   alu_sh_q, alu_sh_d;
  logic [DATA_W-1:0]    rsp_result_q, rsp_result_d;
  logic                 rsp_ovf_q, rsp_ovf_d;
  logic                 rsp_zero_q, rsp_zero_d;

  logic [1:0] grant;
  logic       grant_idx;
  logic       accept;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state_q == IDLE),
    .req       ({req_valid1, req_valid0}),
    .take      (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign accept = |(grant & {req_valid1, req_valid0});

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_op_d     = alu_op_q;
    alu_sh_d     = alu_sh_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = EXEC;
          owner_d   = grant_idx;
          alu_in1_d = grant_idx ? req_in1_1      : req_in1_0;
          alu_in2_d = grant_idx ? req_in2_1      : req_in2_0;
          alu_op_d  = grant_idx ? req_opCode_1   : req_opCode_0;
          alu_sh_d  = grant_idx ? req_shiftAmt_1 : req_shiftAmt_0;
        end
      end
      EXEC: begin
        state_d      = RESP;
        rsp_result_d = alu_result;
        rsp_ovf_d    = alu_overflow;
        rsp_zero_d   = alu_zero;
      end
      RESP: begin
        if (owner_q ? rsp_ready1 : rsp_ready0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_op_q     <= '0;
      alu_sh_q     <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_op_q     <= alu_op_d;
      alu_sh_q     <= alu_sh_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign req_ready0   = grant[0];
  assign req_ready1   = grant[1];
  assign rsp_valid0   = (state_q == RESP) && !owner_q;
  assign rsp_valid1   = (state_q == RESP) && owner_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_ovf_q;
  assign rsp_zero     = rsp_zero_q;
  assign alu_in1      = alu_in1_q;
  assign alu_in2      = alu_in2_q;
  assign alu_opCode   = alu_op_q;
  assign alu_shiftAmt = alu_sh_q;
  assign busy         = (state_q != IDLE);

endmodule
